// File: rtl/dram_wr_seq.sv
// dram_wr_seq: AXI4 write-burst traffic generator with 4 KiB splitting and outstanding-burst limiting
module dram_wr_seq #(
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  start_addr,
  input  logic [31:0]  write_len,
  input  logic [31:0]  write_val,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  cycle_cnt,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {IDLE, AW, W, DRAIN} state_t;

  state_t      st;
  logic [63:0] addr;
  logic [31:0] rem;
  logic [8:0]  bcnt;
  logic [8:0]  aw_beats;
  logic [3:0]  outst;
  logic [3:0]  out_nxt;
  logic [6:0]  sb;
  logic [6:0]  nb;
  logic        aw_hs;
  logic        w_hs;
  logic        b_ok;
  logic        b_err;
  logic        go;
  logic        bid_unused;

  // beats = min(remaining, MAX_BURST, beats left in the 4 KiB page)
  function automatic logic [6:0] beats_f(input logic [5:0] pg, input logic [31:0] r);
    logic [6:0] p;
    p = 7'd64 - {1'b0, pg};
    p = (MAX_BURST < int'(p)) ? 7'(MAX_BURST) : p;
    return (r < {25'd0, p}) ? r[6:0] : p;
  endfunction

  assign awid       = '0;
  assign bready     = 1'b1;
  assign bid_unused = ^{bid, start_addr[5:0]};
  assign sb         = beats_f(start_addr[11:6], write_len);
  assign nb         = beats_f(addr[11:6], rem);
  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign aw_beats   = {1'b0, awlen} + 9'd1;
  assign go         = (st == IDLE) & start;

  // responses only count while a run is active; stray ones never underflow the counter
  always_comb begin
    b_ok    = bvalid & (st != IDLE) & (outst != 4'd0);
    b_err   = bvalid & (st != IDLE) & ((bresp != 2'b00) | (outst == 4'd0));
    out_nxt = (aw_hs & ~b_ok) ? outst + 4'd1 : (~aw_hs & b_ok) ? outst - 4'd1 : outst;
  end

  // outstanding-burst count and sticky response error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= '0;
      err   <= 1'b0;
    end else begin
      outst <= out_nxt;
      err   <= go ? 1'b0 : err | b_err;
    end
  end

  // run length counter, frozen after done until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else if (go) cycle_cnt <= '0;
    else if (busy && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
  end

  // sequencer FSM with registered AXI outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      awsize  <= '0;
      awburst <= '0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      addr    <= '0;
      rem     <= '0;
      bcnt    <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          busy    <= 1'b1;
          addr    <= {32'h0, start_addr[31:6], 6'h0};
          rem     <= write_len;
          wdata   <= {16{write_val}};
          wstrb   <= '1;
          awsize  <= 3'b110;
          awburst <= 2'b01;
          awaddr  <= {32'h0, start_addr[31:6], 6'h0};
          awlen   <= 8'(sb) - 8'd1;
          awvalid <= write_len != 32'd0;
          st      <= (write_len == 32'd0) ? DRAIN : AW;
        end
        AW: if (aw_hs) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          wlast   <= awlen == 8'd0;
          bcnt    <= aw_beats;
          addr    <= addr + {49'd0, aw_beats, 6'd0};
          rem     <= rem - {23'd0, aw_beats};
          st      <= W;
        end else if (!awvalid) begin
          awvalid <= out_nxt < 4'(MAX_OUTSTANDING);
          awaddr  <= addr;
          awlen   <= 8'(nb) - 8'd1;
        end
        W: if (w_hs) begin
          bcnt  <= bcnt - 9'd1;
          wlast <= bcnt == 9'd2;
          if (wlast) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            if (rem != 32'd0) begin
              st      <= AW;
              awvalid <= out_nxt < 4'(MAX_OUTSTANDING);
              awaddr  <= addr;
              awlen   <= 8'(nb) - 8'd1;
            end else begin
              st <= DRAIN;
            end
          end
        end
        DRAIN: if (out_nxt == 4'd0) begin
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
